vga_timing_rx: RTL and testbench

Receive-side VGA timing decoder: consumes the active-low hsync/vsync and vidon stream produced by the 640x480 timing generator, sampled on the same 25 MHz pixel clock. It regenerates active-area pixel coordinates and measures line and frame geometry. It asserts `locked` once consecutive frames match the expected 800x521 timing. It sits downstream of the timing generator, for capture, loopback self-check and on-screen debug overlays.

---
 rtl/vga_timing_rx.sv | 163 ++++++++++++++++
 tb/tb_vga_timing_rx.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_rx.sv
// Receive-side VGA timing decoder: rebuilds pixel coordinates from hsync/vsync/vidon,
// measures line and frame geometry, and locks once consecutive frames match.
//
// state   | meaning
// SEARCH  | no frame reference yet; wait for the first vsync fall
// MEASURE | qualifying frames; good counts consecutive matching frames
// LOCKED  | timing matches; a bad frame pulses timing_err and drops to MEASURE
module vga_timing_rx #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 521,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk25,
    input  logic       rst,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       vidon_in,
    output logic       pix_valid,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frame_start,
    output logic [9:0] line_len,
    output logic [9:0] frame_lines,
    output logic       locked,
    output logic       timing_err
);

    localparam logic [9:0]  H_TOT    = 10'(H_TOTAL);
    localparam logic [9:0]  H_ACT    = 10'(H_ACTIVE);
    localparam logic [10:0] V_TOT    = 11'(V_TOTAL);
    localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
    localparam logic [10:0] WD_LINES = 11'(2 * V_TOTAL);
    localparam logic [3:0]  LOCK_N   = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    state_t      state;
    logic        hs1, hs2, vs1, vs2, vo1;
    logic        line_vid, frame_err;
    logic [9:0]  hcnt, pcnt, acnt;
    logic [10:0] lcnt;
    logic [3:0]  good;

    logic        hfall, vfall, hcnt_sat, line_bad, frame_err_end, frame_good;
    logic [9:0]  meas_len, pcnt_base, acnt_end, acnt_base;
    logic [10:0] lcnt_inc;
    logic [3:0]  good_inc;

    assign hfall     = hs2 & ~hs1;
    assign vfall     = vs2 & ~vs1;
    assign hcnt_sat  = (hcnt == 10'h3ff);
    assign meas_len  = hcnt_sat ? 10'h3ff : hcnt + 10'd1;
    assign line_bad  = (meas_len != H_TOT) || ((pcnt != 10'd0) && (pcnt != H_ACT));
    // A line that ends in the same cycle as a vsync fall still belongs to the old frame.
    assign frame_err_end = frame_err | (hfall & line_bad) | (hcnt_sat & ~hfall);
    assign acnt_end  = acnt + {9'd0, hfall & line_vid};
    assign acnt_base = vfall ? 10'd0 : acnt_end;
    assign pcnt_base = hfall ? 10'd0 : pcnt;
    assign lcnt_inc  = (lcnt == 11'h7ff) ? lcnt : lcnt + 11'd1;
    assign good_inc  = good + 4'd1;
    assign frame_good = (lcnt == V_TOT) && (acnt_end == V_ACT) && !frame_err_end;

    always_ff @(posedge clk25) begin
        if (rst) begin
            hs1         <= 1'b0;
            hs2         <= 1'b0;
            vs1         <= 1'b0;
            vs2         <= 1'b0;
            vo1         <= 1'b0;
            line_vid    <= 1'b0;
            frame_err   <= 1'b0;
            hcnt        <= '0;
            pcnt        <= '0;
            acnt        <= '0;
            lcnt        <= '0;
            good        <= '0;
            state       <= SEARCH;
            pix_valid   <= 1'b0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
            line_len    <= '0;
            frame_lines <= '0;
            locked      <= 1'b0;
            timing_err  <= 1'b0;
        end else begin
            hs1         <= hsync_in;
            hs2         <= hs1;
            vs1         <= vsync_in;
            vs2         <= vs1;
            vo1         <= vidon_in;
            pix_valid   <= vo1;
            frame_start <= vfall;
            timing_err  <= 1'b0;

            if (hfall) begin
                hcnt     <= '0;
                line_len <= meas_len;
                line_vid <= vo1;
            end else begin
                if (!hcnt_sat)
                    hcnt <= hcnt + 10'd1;
                if (vo1)
                    line_vid <= 1'b1;
            end

            if (vo1) begin
                x    <= pcnt_base;
                y    <= acnt_base;
                pcnt <= (pcnt_base == 10'h3ff) ? pcnt_base : pcnt_base + 10'd1;
            end else begin
                pcnt <= pcnt_base;
            end

            acnt      <= acnt_base;
            frame_err <= vfall ? 1'b0 : frame_err_end;

            if (vfall) begin
                lcnt        <= {10'd0, hfall};
                frame_lines <= (lcnt > 11'd1023) ? 10'h3ff : lcnt[9:0];
            end else if (hfall) begin
                lcnt <= lcnt_inc;
            end

            // Too many lines without a frame boundary means vsync is gone.
            if (!vfall && lcnt >= WD_LINES) begin
                state  <= SEARCH;
                locked <= 1'b0;
                good   <= '0;
            end else if (vfall) begin
                case (state)
                    SEARCH: begin
                        state <= MEASURE;
                        good  <= '0;
                    end
                    MEASURE: begin
                        if (frame_good) begin
                            good <= good_inc;
                            if (good_inc >= LOCK_N) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            good <= '0;
                        end
                    end
                    LOCKED: begin
                        if (!frame_good) begin
                            timing_err <= 1'b1;
                            good       <= '0;
                            locked     <= 1'b0;
                            state      <= MEASURE;
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_rx.sv
// Directed bench for vga_timing_rx using a scaled-down 20x10 raster so full frames
// stay short; expected cycle numbers are derived from that raster by hand.
module tb_vga_timing_rx;

    localparam int HT = 20;
    localparam int HA = 12;
    localparam int VT = 10;
    localparam int VA = 6;
    localparam int LF = 2;

    logic       clk25 = 1'b0;
    logic       rst;
    logic       hsync_in, vsync_in, vidon_in;
    logic       pix_valid, frame_start, locked, timing_err;
    logic [9:0] x, y, line_len, frame_lines;

    always #5 clk25 = ~clk25;

    vga_timing_rx #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(LF)
    ) dut (
        .clk25(clk25), .rst(rst), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .vidon_in(vidon_in), .pix_valid(pix_valid), .x(x), .y(y),
        .frame_start(frame_start), .line_len(line_len), .frame_lines(frame_lines),
        .locked(locked), .timing_err(timing_err)
    );

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0, hc = 0, vc = 0;
    bit   force_h = 0, force_v = 0, stretch_arm = 0, model_on = 0, allow_lock_chg = 0;
    int   fs_cnt = 0, te_cnt = 0, lock_glitch = 0, lock_rise_cyc = -1, lock_rise_fs = -1;
    int   fs_cyc_a[64];
    logic fs_te_a[64], fs_lk_a[64];
    logic [9:0] fs_fl_a[64];
    logic lk_prev = 1'b0;
    bit   saw_len21 = 0;
    int   x_max = 0;
    logic vd1 = 1'b0, vd2 = 1'b0;
    int   hd1 = 0, hd2 = 0, vd1c = 0, vd2c = 0;
    int   fs_base;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One pixel clock: observe outputs at the falling edge, then drive the next raster pixel.
    task automatic tick();
        @(negedge clk25);
        if (frame_start === 1'b1) begin
            if (fs_cnt < 64) begin
                fs_cyc_a[fs_cnt] = cyc;
                fs_te_a[fs_cnt]  = timing_err;
                fs_lk_a[fs_cnt]  = locked;
                fs_fl_a[fs_cnt]  = frame_lines;
            end
            fs_cnt++;
        end
        if (timing_err === 1'b1) te_cnt++;
        if (locked !== lk_prev && frame_start !== 1'b1 && !allow_lock_chg) lock_glitch++;
        if (locked === 1'b1 && lk_prev !== 1'b1) begin
            lock_rise_cyc = cyc;
            lock_rise_fs  = fs_cnt;
        end
        lk_prev = locked;
        if (line_len === 10'd21) saw_len21 = 1;
        if (model_on) begin
            chk("pix_valid", 32'(pix_valid), 32'(vd2));
            if (vd2) begin
                chk("x", 32'(x), hd2);
                chk("y", 32'(y), vd2c);
            end
            if (pix_valid === 1'b1 && int'(x) > x_max) x_max = int'(x);
        end

        vidon_in = (hc < HA) && (vc < VA);
        hsync_in = !(hc >= 14 && hc < 16) || force_h;
        vsync_in = (vc != 7) || force_v;
        vd2 = vd1;  hd2 = hd1;  vd2c = vd1c;
        vd1 = vidon_in;  hd1 = hc;  vd1c = vc;
        hc++;
        if (hc >= ((stretch_arm && vc == 2) ? HT + 1 : HT)) begin
            if (stretch_arm && vc == 2) stretch_arm = 0;
            hc = 0;
            vc = (vc + 1) % VT;
        end
        cyc++;
    endtask

    initial begin
        rst = 1'b1;  hsync_in = 1'b1;  vsync_in = 1'b1;  vidon_in = 1'b0;
        repeat (3) @(negedge clk25);
        chk("rst_pix_valid", 32'(pix_valid), 0);
        chk("rst_xy", {12'd0, x, y}, 0);
        chk("rst_frame_start", 32'(frame_start), 0);
        chk("rst_line_len", 32'(line_len), 0);
        chk("rst_frame_lines", 32'(frame_lines), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_timing_err", 32'(timing_err), 0);
        chk("rst_state", 32'(2'(dut.state)), 0);
        rst = 1'b0;

        // Acquisition from reset: vsync falls at raster cycle 140, 340, 540.
        repeat (600) tick();
        chk("fs_count_3", fs_cnt, 3);
        chk("fs1_cycle", fs_cyc_a[0], 142);
        chk("fs1_frame_lines", 32'(fs_fl_a[0]), 7);
        chk("fs2_frame_lines", 32'(fs_fl_a[1]), 10);
        chk("line_len", 32'(line_len), 20);
        chk("lock_rise_fs", lock_rise_fs, 3);
        chk("lock_rise_cycle", lock_rise_cyc, 542);
        chk("lock_after_fs1", fs_cyc_a[2] - fs_cyc_a[0], 400);
        chk("locked", 32'(locked), 1);

        // Locked stream with coordinate model; raster line 2 stretched to 21 clocks.
        model_on = 1;
        stretch_arm = 1;
        for (int i = 0; i < 2000 && fs_cnt < 6; i++) tick();
        chk("fs6_reached", 32'(fs_cnt >= 6), 1);
        chk("saw_len21", 32'(saw_len21), 1);
        chk("fs4_cycle", fs_cyc_a[3], 743);
        chk("fs4_timing_err", 32'(fs_te_a[3]), 1);
        chk("fs4_locked", 32'(fs_lk_a[3]), 0);
        chk("fs5_timing_err", 32'(fs_te_a[4]), 0);
        chk("fs5_locked", 32'(fs_lk_a[4]), 0);
        chk("fs6_locked", 32'(fs_lk_a[5]), 1);
        chk("te_pulses", te_cnt, 1);
        chk("x_max", x_max, HA - 1);

        // hsync and vsync stuck high.
        model_on = 0;
        force_h = 1;  force_v = 1;
        repeat (1100) tick();
        chk("hcnt_saturated", 32'(dut.hcnt), 1023);
        chk("stuck_locked", 32'(locked), 1);
        chk("stuck_no_fs", fs_cnt, 6);

        // vsync alone held high: watchdog after 2*VT lines.
        force_h = 0;
        allow_lock_chg = 1;
        for (int i = 0; i < 1000 && dut.lcnt < 11'(2 * VT); i++) tick();
        chk("lcnt_reach", 32'(dut.lcnt), 2 * VT);
        chk("wd_locked_before", 32'(locked), 1);
        tick();
        chk("wd_locked_after", 32'(locked), 0);
        chk("wd_state_search", 32'(2'(dut.state)), 0);
        chk("wd_no_timing_err", te_cnt, 1);
        allow_lock_chg = 0;

        // Re-acquire, then a single-cycle reset mid-frame.
        force_v = 0;
        for (int i = 0; i < 2000 && locked !== 1'b1; i++) tick();
        chk("relock_after_wd", 32'(locked), 1);
        for (int i = 0; i < 400 && !(vc == 3 && hc == 5); i++) tick();
        allow_lock_chg = 1;
        fs_base = fs_cnt;
        rst = 1'b1;
        tick();
        chk("mid_rst_pix_valid", 32'(pix_valid), 0);
        chk("mid_rst_xy", {12'd0, x, y}, 0);
        chk("mid_rst_frame_start", 32'(frame_start), 0);
        chk("mid_rst_line_len", 32'(line_len), 0);
        chk("mid_rst_frame_lines", 32'(frame_lines), 0);
        chk("mid_rst_locked", 32'(locked), 0);
        chk("mid_rst_timing_err", 32'(timing_err), 0);
        rst = 1'b0;
        tick();
        allow_lock_chg = 0;
        for (int i = 0; i < 2000 && locked !== 1'b1; i++) tick();
        chk("relock_after_rst", 32'(locked), 1);
        chk("relock_fs_count", lock_rise_fs - fs_base, 3);
        chk("lock_only_at_fs", lock_glitch, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed cycle %0d required finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
